// File: rtl/memory_reader_if.sv
// Memory read port plus downstream valid/ready stream of memory_reader.
// The master modport is the reader; the slave modport is the memory/consumer side.
interface memory_reader_if #(
  parameter int RAM_WIDTH = 18,
  parameter int RAM_DEPTH = 1024,
  parameter int NBINS     = 8
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int BW = (NBINS > 1) ? $clog2(NBINS) : 1;

  logic [AW-1:0]        addrb;
  logic                 enb;
  logic                 regceb;
  logic                 rstb;
  logic [RAM_WIDTH-1:0] doutb;
  logic [RAM_WIDTH-1:0] dout;
  logic [BW-1:0]        dout_bin;
  logic                 dout_valid;
  logic                 dout_ready;

  modport master (
    output addrb, enb, regceb, rstb, dout, dout_bin, dout_valid,
    input  doutb, dout_ready
  );

  modport slave (
    input  addrb, enb, regceb, rstb, dout, dout_bin, dout_valid,
    output doutb, dout_ready
  );
endinterface

// File: rtl/memory_reader.sv
// Walks every bin of a binned memory, reads the snapshotted number of entries per bin
// and streams the words out in bin/entry order through a credit-protected 4-deep FIFO.
module memory_reader #(
  parameter int RAM_WIDTH = 18,
  parameter int RAM_DEPTH = 1024,
  parameter int NBINS     = 8
) (
  input  logic               clkb,
  input  logic               rstb_n,
  input  logic               start,
  input  logic [8*NBINS-1:0] nent_i,
  output logic               busy,
  output logic               done,
  memory_reader_if.master    bus
);
  localparam int AW    = $clog2(RAM_DEPTH);
  localparam int BW    = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam int BINSZ = RAM_DEPTH / NBINS;
  localparam int CW    = $clog2(BINSZ + 1);
  localparam int FDEPTH = 4;

  typedef enum logic [2:0] {IDLE, SCAN, READ, DRAIN, DONE} state_t;

  state_t               state_q;
  logic [BW-1:0]        bin_q;
  logic [CW-1:0]        entry_q;
  logic [CW-1:0]        cnt_q [NBINS];
  logic [CW-1:0]        cnt_d [NBINS];
  logic [AW-1:0]        addr_q;
  logic                 enb_q;
  logic [BW-1:0]        issueBin_q;
  logic                 busy_q;
  logic                 done_q;

  logic [1:0]           pipeValid_q;
  logic [BW-1:0]        pipeBin_q [2];

  logic [RAM_WIDTH-1:0] fifoData_q [FDEPTH];
  logic [BW-1:0]        fifoBin_q [FDEPTH];
  logic [1:0]           wrPtr_q;
  logic [1:0]           rdPtr_q;
  logic [2:0]           occ_q;

  logic                 push;
  logic                 pop;
  logic [2:0]           pending;
  logic                 canIssue;
  logic                 lastEntry;
  logic                 lastBin;

  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      if (int'(nent_i[8*b +: 8]) > BINSZ) cnt_d[b] = CW'(BINSZ);
      else                                cnt_d[b] = CW'(nent_i[8*b +: 8]);
    end
  end

  // A pop in the same cycle frees a slot, which keeps full throughput with ready held high.
  assign push      = pipeValid_q[1];
  assign pop       = (occ_q != 3'd0) && bus.dout_ready;
  assign pending   = occ_q + 3'(enb_q) + 3'(pipeValid_q[0]) + 3'(pipeValid_q[1]);
  assign canIssue  = (pending - 3'(pop)) < 3'd4;
  assign lastEntry = (entry_q == cnt_q[bin_q] - CW'(1));
  assign lastBin   = (bin_q == BW'(NBINS - 1));

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      entry_q    <= '0;
      addr_q     <= '0;
      enb_q      <= 1'b0;
      issueBin_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int b = 0; b < NBINS; b++) cnt_q[b] <= '0;
    end else begin
      enb_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int b = 0; b < NBINS; b++) cnt_q[b] <= cnt_d[b];
            bin_q   <= '0;
            entry_q <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (cnt_q[bin_q] != '0) begin
            entry_q <= '0;
            state_q <= READ;
          end else if (lastBin) begin
            state_q <= DRAIN;
          end else begin
            bin_q <= bin_q + BW'(1);
          end
        end
        READ: begin
          if (canIssue) begin
            addr_q     <= AW'(int'(bin_q) * BINSZ + int'(entry_q));
            enb_q      <= 1'b1;
            issueBin_q <= bin_q;
            if (lastEntry) begin
              entry_q <= '0;
              if (lastBin) begin
                state_q <= DRAIN;
              end else begin
                bin_q   <= bin_q + BW'(1);
                state_q <= SCAN;
              end
            end else begin
              entry_q <= entry_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (pending == 3'd0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-stage tracker matches the memory latency; its tail is the FIFO write strobe.
  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      pipeValid_q <= '0;
      pipeBin_q[0] <= '0;
      pipeBin_q[1] <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      occ_q       <= '0;
      for (int i = 0; i < FDEPTH; i++) begin
        fifoData_q[i] <= '0;
        fifoBin_q[i]  <= '0;
      end
    end else begin
      pipeValid_q  <= {pipeValid_q[0], enb_q};
      pipeBin_q[0] <= issueBin_q;
      pipeBin_q[1] <= pipeBin_q[0];
      if (push) begin
        fifoData_q[wrPtr_q] <= bus.doutb;
        fifoBin_q[wrPtr_q]  <= pipeBin_q[1];
        wrPtr_q             <= wrPtr_q + 2'd1;
      end
      if (pop) rdPtr_q <= rdPtr_q + 2'd1;
      occ_q <= occ_q + 3'(push) - 3'(pop);
    end
  end

  assign bus.addrb      = addr_q;
  assign bus.enb        = enb_q;
  assign bus.regceb     = enb_q;
  assign bus.rstb       = 1'b0;
  assign bus.dout       = fifoData_q[rdPtr_q];
  assign bus.dout_bin   = fifoBin_q[rdPtr_q];
  assign bus.dout_valid = (occ_q != 3'd0);
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_memory_reader.sv
// Randomised bench for memory_reader: a 2-cycle-latency memory model, a queue-based
// expectation of addresses/words per run, and a negedge monitor on both buses.
module tb_memory_reader;
  localparam int RAM_WIDTH = 18;
  localparam int RAM_DEPTH = 1024;
  localparam int NBINS     = 8;
  localparam int AW        = $clog2(RAM_DEPTH);
  localparam int BW        = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam int BINSZ     = RAM_DEPTH / NBINS;

  logic               clkb;
  logic               rstb_n;
  logic               start;
  logic [8*NBINS-1:0] nent_i;
  logic               busy;
  logic               done;

  memory_reader_if #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .NBINS(NBINS)) bus ();

  memory_reader #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .NBINS(NBINS)) dut (
    .clkb   (clkb),
    .rstb_n (rstb_n),
    .start  (start),
    .nent_i (nent_i),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  logic [RAM_WIDTH-1:0] memArr [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] memPipe;

  int expAddrQ[$];
  int expWordAddrQ[$];
  int expBinQ[$];

  int passCnt = 0;
  int totalCnt = 0;
  int cycleCnt = 0;
  int issuedCnt, xferCnt, gapCnt, doneCount, doneCycle, startCyc, lastXfer, maxOut, expTotal;
  int monA, monB, outNow;
  bit validSeen, timedOut;

  initial begin
    clkb = 1'b0;
    forever #5 clkb = ~clkb;
  end

  initial begin
    forever begin
      @(posedge clkb);
      cycleCnt++;
    end
  end

  // Memory: address sampled on the edge after issue, data presented one edge later.
  initial begin
    memPipe   = '0;
    bus.doutb = '0;
    forever begin
      @(posedge clkb);
      if (bus.enb === 1'b1) memPipe <= memArr[bus.addrb];
      bus.doutb <= memPipe;
    end
  end

  // Every issue and every transfer is checked against the expectation queues.
  initial begin
    forever begin
      @(negedge clkb);
      if (rstb_n === 1'b1) begin
        if (bus.enb === 1'b1) begin
          issuedCnt++;
          totalCnt++;
          if (expAddrQ.size() == 0) begin
            $display("[TB] FAIL issue_extra: got addr %0d, required no issue", bus.addrb);
          end else begin
            monA = expAddrQ.pop_front();
            if (bus.addrb !== AW'(monA) || bus.regceb !== 1'b1)
              $display("[TB] FAIL issue_addr: got addr %0d regceb %b, required addr %0d regceb 1",
                       bus.addrb, bus.regceb, monA);
            else passCnt++;
          end
        end
        outNow = issuedCnt - xferCnt;
        if (outNow > maxOut) maxOut = outNow;
        if (bus.dout_valid === 1'b1) validSeen = 1'b1;
        if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
          if (xferCnt > 0 && lastXfer != cycleCnt - 1) gapCnt++;
          lastXfer = cycleCnt;
          xferCnt++;
          totalCnt++;
          if (expWordAddrQ.size() == 0) begin
            $display("[TB] FAIL word_extra: got data %0h bin %0d, required no transfer", bus.dout, bus.dout_bin);
          end else begin
            monA = expWordAddrQ.pop_front();
            monB = expBinQ.pop_front();
            if (bus.dout !== memArr[monA] || bus.dout_bin !== BW'(monB))
              $display("[TB] FAIL word: got data %0h bin %0d, required data %0h bin %0d (addr %0d)",
                       bus.dout, bus.dout_bin, memArr[monA], monB, monA);
            else passCnt++;
          end
        end
        if (done === 1'b1) begin
          doneCount++;
          doneCycle = cycleCnt;
        end
      end
    end
  end

  task automatic loadModel(input logic [8*NBINS-1:0] nent);
    expAddrQ.delete();
    expWordAddrQ.delete();
    expBinQ.delete();
    expTotal = 0;
    for (int b = 0; b < NBINS; b++) begin
      int n;
      n = int'(nent[8*b +: 8]);
      if (n > BINSZ) n = BINSZ;
      for (int e = 0; e < n; e++) begin
        expAddrQ.push_back(b * BINSZ + e);
        expWordAddrQ.push_back(b * BINSZ + e);
        expBinQ.push_back(b);
        expTotal++;
      end
    end
  endtask

  task automatic clearStats();
    issuedCnt = 0;
    xferCnt   = 0;
    gapCnt    = 0;
    doneCount = 0;
    doneCycle = 0;
    lastXfer  = 0;
    maxOut    = 0;
    validSeen = 1'b0;
  endtask

  function automatic logic readyFor(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: return 1'($urandom_range(0, 1));
      default: begin
        if (cyc < 8) return 1'b1;
        if (cyc < 12) return (cyc % 2 == 0);
        if (cyc < 32) return 1'b0;
        return 1'b1;
      end
    endcase
  endfunction

  task automatic runSeq(input logic [8*NBINS-1:0] nent, input int mode, input int budget,
                        input int reStartAt, input logic [8*NBINS-1:0] nentAlt);
    int cyc;
    loadModel(nent);
    clearStats();
    nent_i = nent;
    start = 1'b1;
    bus.dout_ready = readyFor(mode, 0);
    startCyc = cycleCnt;
    cyc = 0;
    while (doneCount == 0 && cyc < budget) begin
      @(posedge clkb); #1;
      cyc++;
      start = 1'b0;
      if (cyc == reStartAt) begin
        nent_i = nentAlt;
        start = 1'b1;
      end
      bus.dout_ready = readyFor(mode, cyc);
    end
    start = 1'b0;
    timedOut = (doneCount == 0);
    repeat (4) @(posedge clkb);
    #1;
  endtask

  task automatic test_reset();
    rstb_n = 1'b0;
    #1;
    totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, required 0", busy); else passCnt++;
    totalCnt++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b, required 0", done); else passCnt++;
    totalCnt++; if (bus.dout_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b, required 0", bus.dout_valid); else passCnt++;
    totalCnt++; if ({bus.enb, bus.regceb} !== 2'b00) $display("[TB] FAIL reset_enb: got %b, required 00", {bus.enb, bus.regceb}); else passCnt++;
    totalCnt++; if (bus.addrb !== '0) $display("[TB] FAIL reset_addrb: got %0d, required 0", bus.addrb); else passCnt++;
    totalCnt++; if ({bus.dout, bus.dout_bin} !== '0) $display("[TB] FAIL reset_dout: got %0h, required 0", {bus.dout, bus.dout_bin}); else passCnt++;
    totalCnt++; if (bus.rstb !== 1'b0) $display("[TB] FAIL reset_rstb: got %b, required 0", bus.rstb); else passCnt++;
    repeat (3) @(posedge clkb);
    #1;
    rstb_n = 1'b1;
    repeat (2) @(posedge clkb);
    #1;
  endtask

  task automatic test_basic();
    logic [8*NBINS-1:0] nent;
    nent = '0;
    nent[7:0] = 8'd3;
    nent[8*7 +: 8] = 8'd1;
    runSeq(nent, 0, 200, -1, '0);
    totalCnt++; if (timedOut) $display("[TB] FAIL basic_done_timeout: got no done, required done"); else passCnt++;
    totalCnt++; if (doneCount !== 1) $display("[TB] FAIL basic_done_count: got %0d, required 1", doneCount); else passCnt++;
    totalCnt++; if (xferCnt !== 4) $display("[TB] FAIL basic_words: got %0d, required 4", xferCnt); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_after: got %b, required 0", busy); else passCnt++;
    totalCnt++; if (bus.rstb !== 1'b0) $display("[TB] FAIL basic_rstb: got %b, required 0", bus.rstb); else passCnt++;
  endtask

  task automatic test_all_zero();
    runSeq('0, 1, 100, -1, '0);
    totalCnt++; if (timedOut) $display("[TB] FAIL zero_done_timeout: got no done, required done"); else passCnt++;
    totalCnt++;
    if (doneCycle - startCyc > NBINS + 3)
      $display("[TB] FAIL zero_latency: got %0d cycles, required at most %0d", doneCycle - startCyc, NBINS + 3);
    else passCnt++;
    totalCnt++; if (validSeen !== 1'b0) $display("[TB] FAIL zero_valid: got dout_valid 1, required never"); else passCnt++;
    totalCnt++; if (issuedCnt !== 0) $display("[TB] FAIL zero_issue: got %0d issues, required 0", issuedCnt); else passCnt++;
  endtask

  task automatic test_backpressure();
    logic [8*NBINS-1:0] nent;
    nent = '0;
    nent[8*2 +: 8] = 8'd10;
    runSeq(nent, 2, 300, -1, '0);
    totalCnt++; if (timedOut) $display("[TB] FAIL bp_done_timeout: got no done, required done"); else passCnt++;
    totalCnt++; if (xferCnt !== 10) $display("[TB] FAIL bp_words: got %0d, required 10", xferCnt); else passCnt++;
    totalCnt++; if (maxOut > 4) $display("[TB] FAIL bp_outstanding: got %0d, required at most 4", maxOut); else passCnt++;
    totalCnt++;
    if (expWordAddrQ.size() + expAddrQ.size() != 0)
      $display("[TB] FAIL bp_leftover: got %0d pending, required 0", expWordAddrQ.size() + expAddrQ.size());
    else passCnt++;
  endtask

  task automatic test_clamp();
    logic [8*NBINS-1:0] nent;
    nent = '0;
    nent[7:0] = 8'd200;
    runSeq(nent, 0, 400, -1, '0);
    totalCnt++; if (timedOut) $display("[TB] FAIL clamp_done_timeout: got no done, required done"); else passCnt++;
    totalCnt++; if (xferCnt !== BINSZ) $display("[TB] FAIL clamp_words: got %0d, required %0d", xferCnt, BINSZ); else passCnt++;
    totalCnt++; if (gapCnt !== 0) $display("[TB] FAIL clamp_throughput: got %0d gaps, required 0", gapCnt); else passCnt++;
  endtask

  task automatic test_reset_mid();
    logic [8*NBINS-1:0] nent;
    int cyc;
    nent = '0;
    nent[8*1 +: 8] = 8'd20;
    loadModel(nent);
    clearStats();
    nent_i = nent;
    bus.dout_ready = 1'b1;
    start = 1'b1;
    @(posedge clkb); #1;
    start = 1'b0;
    cyc = 0;
    while (issuedCnt < 5 && cyc < 50) begin
      @(posedge clkb); #1;
      cyc++;
    end
    totalCnt++; if (issuedCnt < 5) $display("[TB] FAIL midreset_issue_timeout: got %0d issues, required 5", issuedCnt); else passCnt++;
    #2;
    rstb_n = 1'b0;
    #1;
    totalCnt++;
    if ({busy, done, bus.dout_valid, bus.enb, bus.regceb, bus.addrb, bus.dout, bus.dout_bin} !== '0)
      $display("[TB] FAIL midreset_outputs: got busy %b valid %b enb %b addr %0d dout %0h, required all 0",
               busy, bus.dout_valid, bus.enb, bus.addrb, bus.dout);
    else passCnt++;
    repeat (2) @(posedge clkb);
    #1;
    expAddrQ.delete();
    expWordAddrQ.delete();
    expBinQ.delete();
    rstb_n = 1'b1;
    repeat (2) @(posedge clkb);
    #1;
    runSeq(nent, 0, 200, -1, '0);
    totalCnt++; if (timedOut) $display("[TB] FAIL midreset_done_timeout: got no done, required done"); else passCnt++;
    totalCnt++; if (xferCnt !== 20) $display("[TB] FAIL midreset_words: got %0d, required 20", xferCnt); else passCnt++;
  endtask

  task automatic test_restart_ignored();
    logic [8*NBINS-1:0] nentA;
    logic [8*NBINS-1:0] nentB;
    nentA = '0;
    nentA[8*3 +: 8] = 8'd6;
    nentA[8*5 +: 8] = 8'd4;
    nentB = '0;
    nentB[7:0] = 8'd5;
    runSeq(nentA, 1, 300, 4, nentB);
    totalCnt++; if (timedOut) $display("[TB] FAIL restart_done_timeout: got no done, required done"); else passCnt++;
    totalCnt++; if (doneCount !== 1) $display("[TB] FAIL restart_done_count: got %0d, required 1", doneCount); else passCnt++;
    totalCnt++; if (xferCnt !== 10) $display("[TB] FAIL restart_words: got %0d, required 10", xferCnt); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL restart_busy_after: got %b, required 0", busy); else passCnt++;
  endtask

  task automatic test_random();
    logic [8*NBINS-1:0] nent;
    for (int it = 0; it < 3; it++) begin
      for (int b = 0; b < NBINS; b++) nent[8*b +: 8] = 8'($urandom_range(0, 12));
      if (it == 0) nent[8*$urandom_range(0, NBINS - 1) +: 8] = 8'($urandom_range(129, 255));
      runSeq(nent, 1, 3000, -1, '0);
      totalCnt++; if (timedOut) $display("[TB] FAIL rand%0d_done_timeout: got no done, required done", it); else passCnt++;
      totalCnt++; if (xferCnt !== expTotal) $display("[TB] FAIL rand%0d_words: got %0d, required %0d", it, xferCnt, expTotal); else passCnt++;
      totalCnt++; if (maxOut > 4) $display("[TB] FAIL rand%0d_outstanding: got %0d, required at most 4", it, maxOut); else passCnt++;
      totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL rand%0d_busy_after: got %b, required 0", it, busy); else passCnt++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstb_n = 1'b1;
    start = 1'b0;
    nent_i = '0;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) memArr[i] = RAM_WIDTH'($urandom);
    clearStats();
    #2;
    test_reset();
    test_basic();
    test_all_zero();
    test_backpressure();
    test_clamp();
    test_reset_mid();
    test_restart_ignored();
    test_random();
    $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
